// File: rtl/spi_slave.sv
// Byte-oriented SPI responder: oversamples sclk/ss_n/mosi in the clk_i domain,
// shifts MOSI into dout_o and drives din_i out on MISO, MSB first.
//
// state | meaning
// IDLE  | deselected or disarmed; MISO tri-stated, waiting for armed ss_n fall
// XFER  | selected; sampling MOSI and shifting MISO on SCLK edges
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  sclk_i,
  input  logic                  ss_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  spi_done_tick_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {IDLE, XFER} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   ss_dly_q, ss_dly_d;
  logic                   armed_q, armed_d;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0]  tx_q, tx_d;
  logic [DATA_WIDTH-2:0]  rx_q, rx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                   tick_q, tick_d;
  logic                   miso_q, miso_d;

  logic                   sclk_s, ss_s, mosi_s;
  logic                   lead, trail, sample, shift, last;
  logic [DATA_WIDTH-1:0]  rx_shift;

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign lead     = (sclk_dly_q == cpol_q) && (sclk_s != cpol_q);
  assign trail    = (sclk_dly_q != cpol_q) && (sclk_s == cpol_q);
  assign sample   = cpha_q ? trail : lead;
  // In mode cpha=0 the trailing edge right after a completed byte must not
  // shift, otherwise the freshly reloaded MSB would be lost.
  assign shift    = cpha_q ? lead : (trail && (cnt_q != '0));
  assign last     = sample && (cnt_q == CW'(DATA_WIDTH - 1));
  assign rx_shift = {rx_q, mosi_s};

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    sclk_dly_d  = sclk_s;
    ss_dly_d    = ss_s;
    // Arm only on a real sample of ss_n high, not on the reset-filled chain.
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ss_s);
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    tick_d      = 1'b0;
    miso_d      = miso_q;

    case (state_q)
      IDLE: begin
        if (armed_q && ss_dly_q && !ss_s) begin
          cpol_d     = cpol_i;
          cpha_d     = cpha_i;
          cnt_d      = '0;
          sclk_dly_d = sclk_s;
          state_d    = XFER;
          if (cpha_i) begin
            tx_d = din_i;
          end else begin
            tx_d   = {din_i[DATA_WIDTH-2:0], 1'b0};
            miso_d = din_i[DATA_WIDTH-1];
          end
        end
      end
      XFER: begin
        if (ss_s) begin
          state_d = IDLE;
          if (last) begin
            dout_d = rx_shift;
            tick_d = 1'b1;
            cnt_d  = '0;
          end
        end else begin
          if (tick_q) begin
            if (cpha_q) begin
              tx_d = din_i;
            end else begin
              tx_d   = {din_i[DATA_WIDTH-2:0], 1'b0};
              miso_d = din_i[DATA_WIDTH-1];
            end
          end else if (shift) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (sample) begin
            rx_d = rx_shift[DATA_WIDTH-2:0];
            if (last) begin
              dout_d = rx_shift;
              tick_d = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b1;
      armed_q     <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      tick_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      sclk_dly_q  <= sclk_dly_d;
      ss_dly_q    <= ss_dly_d;
      armed_q     <= armed_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      tick_q      <= tick_d;
      miso_q      <= miso_d;
    end
  end

  assign miso_o          = miso_q;
  assign miso_oe_o       = (state_q == XFER);
  assign busy_o          = (state_q == XFER);
  assign dout_o          = dout_q;
  assign spi_done_tick_o = tick_q;

endmodule
